// File: rtl/rshift_round_sat_pkg.sv
// Shared constants for the FFT rescaling datapath: default sample width,
// saturation limits and the rounding constant for a right shift.
package rshift_round_sat_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;

   // Largest signed value representable in w bits.
   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   // Most negative signed value representable in w bits.
   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

   // Half an output LSB, so that truncation after the shift rounds half-up.
   function automatic longint round_const(input int shift);
      if (shift > 0) begin
         return longint'(1) <<< (shift - 1);
      end
      return longint'(0);
   endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational clip of a (2*DATA_WIDTH+1)-bit signed value into DATA_WIDTH
// bits, flagging any value that had to be clipped.
module sat_clip
   import rshift_round_sat_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic signed [2*DATA_WIDTH:0]   q,
   output logic        [DATA_WIDTH-1:0]   d,
   output logic                           sat
);

   localparam int WIDE_W = 2 * DATA_WIDTH + 1;
   localparam logic signed [WIDE_W-1:0] HI = WIDE_W'(sat_max(DATA_WIDTH));
   localparam logic signed [WIDE_W-1:0] LO = WIDE_W'(sat_min(DATA_WIDTH));

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      d   = q[DATA_WIDTH-1:0];
      sat = 1'b0;
      if (q > HI) begin
         d   = HI[DATA_WIDTH-1:0];
         sat = 1'b1;
      end else if (q < LO) begin
         d   = LO[DATA_WIDTH-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/rshift_round_sat.sv
// Two-stage rescaler: wide signed sample -> arithmetic right shift with
// round-half-up -> saturation, with valid/ready flow control and overflow stats.
module rshift_round_sat
   import rshift_round_sat_pkg::*;
#(
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int RSHIFT_AMOUNT = 8,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr_ovf,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [2*DATA_WIDTH-1:0] D_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic        [DATA_WIDTH-1:0]   D_out,
   output logic                           out_sat,
   output logic                           ovf_sticky,
   output logic        [CNT_WIDTH-1:0]    ovf_count
);

   localparam int IN_W  = 2 * DATA_WIDTH;
   localparam int SUM_W = IN_W + 1;
   localparam logic signed [SUM_W-1:0] ROUND   = SUM_W'(round_const(RSHIFT_AMOUNT));
   localparam logic        [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                    s1_valid;
   logic signed [SUM_W-1:0] s1_sum;
   logic signed [SUM_W-1:0] q;
   logic [DATA_WIDTH-1:0]   clip_d;
   logic                    clip_sat;
   logic                    s1_advance;
   logic                    s2_advance;
   logic                    sat_xfer;

   // NOTE: in_ready is a pure function of current occupancy and out_ready, so a
   // stalled output frees the input port in the same cycle it is released.
   assign s2_advance = !out_valid || out_ready;
   assign s1_advance = !s1_valid || s2_advance;
   assign in_ready   = s1_advance;
   assign sat_xfer   = out_valid && out_ready && out_sat;

   assign q = s1_sum >>> RSHIFT_AMOUNT;

   sat_clip #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_sat_clip (
      .q   (q),
      .d   (clip_d),
      .sat (clip_sat)
   );

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values present before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
      end else if (s1_advance) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            // One guard bit keeps the rounding add from wrapping near full scale.
            s1_sum <= {D_in[IN_W-1], D_in} + ROUND;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         D_out     <= '0;
         out_sat   <= 1'b0;
      end else if (s2_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            D_out   <= clip_d;
            out_sat <= clip_sat;
         end
      end
   end

   // A clear coinciding with a saturated transfer still records that transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
         ovf_count  <= '0;
      end else if (clr_ovf) begin
         ovf_sticky <= sat_xfer;
         ovf_count  <= sat_xfer ? CNT_WIDTH'(1) : '0;
      end else if (sat_xfer) begin
         ovf_sticky <= 1'b1;
         if (ovf_count != CNT_MAX) begin
            ovf_count <= ovf_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_rshift_round_sat.sv
// Bench for rshift_round_sat: an occupancy/queue model of the pipeline with
// arithmetic rescaling, checked every cycle, plus hand-computed vectors.
module tb_rshift_round_sat;

   localparam int DW    = 16;
   localparam int SHIFT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_ovf = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] D_in = 32'h0;

   logic        in_ready, out_valid, out_sat, ovf_sticky;
   logic [15:0] D_out, ovf_count;
   logic        in_ready_s, out_valid_s, out_sat_s, ovf_sticky_s;
   logic [15:0] D_out_s;
   logic [2:0]  ovf_count_s;

   int vectors = 0;
   int miscompares = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   rshift_round_sat #(.DATA_WIDTH(DW), .RSHIFT_AMOUNT(SHIFT), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .clr_ovf(clr_ovf), .in_valid(in_valid), .in_ready(in_ready),
      .D_in(D_in), .out_valid(out_valid), .out_ready(out_ready), .D_out(D_out),
      .out_sat(out_sat), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
   );

   // Narrow-counter copy on the same stimulus, to reach the counter ceiling quickly.
   rshift_round_sat #(.DATA_WIDTH(DW), .RSHIFT_AMOUNT(SHIFT), .CNT_WIDTH(3)) dut_small (
      .clk(clk), .rst(rst), .clr_ovf(clr_ovf), .in_valid(in_valid), .in_ready(in_ready_s),
      .D_in(D_in), .out_valid(out_valid_s), .out_ready(out_ready), .D_out(D_out_s),
      .out_sat(out_sat_s), .ovf_sticky(ovf_sticky_s), .ovf_count(ovf_count_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [15:0] d;
      logic        sat;
      int          age;
   } entry_t;

   entry_t q_m[$];
   bit     m_sticky = 1'b0;
   int     m_count = 0;
   int     m_count_s = 0;

   function automatic void rescale(input logic [31:0] x, output logic [15:0] d, output logic sat);
      longint v, r;
      v = longint'($signed(x));
      r = (v + 128) >>> SHIFT;
      if (r > 32767) begin
         d = 16'h7FFF; sat = 1'b1;
      end else if (r < -32768) begin
         d = 16'h8000; sat = 1'b1;
      end else begin
         d = r[15:0]; sat = 1'b0;
      end
   endfunction

   function automatic bit m_visible();
      return (q_m.size() > 0) && (q_m[0].age >= 1);
   endfunction

   function automatic bit m_in_ready();
      return (q_m.size() < 2) || out_ready;
   endfunction

   always @(posedge clk) begin
      bit in_x, out_x, sat_ev;
      entry_t e;
      in_x  = in_valid && m_in_ready();
      out_x = m_visible() && out_ready;
      if (rst) begin
         q_m.delete();
         m_sticky = 1'b0; m_count = 0; m_count_s = 0;
      end else begin
         sat_ev = out_x && q_m[0].sat;
         if (clr_ovf) begin
            m_sticky = 1'b0; m_count = 0; m_count_s = 0;
         end
         if (sat_ev) begin
            m_sticky = 1'b1;
            if (m_count < 65535) m_count++;
            if (m_count_s < 7) m_count_s++;
         end
         foreach (q_m[i]) q_m[i].age++;
         if (out_x) void'(q_m.pop_front());
         if (in_x) begin
            rescale(D_in, e.d, e.sat);
            e.age = 0;
            q_m.push_back(e);
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("out_valid", 32'(out_valid), 32'(m_visible()));
         check("in_ready", 32'(in_ready), 32'(m_in_ready()));
         check("out_valid_small", 32'(out_valid_s), 32'(m_visible()));
         check("in_ready_small", 32'(in_ready_s), 32'(m_in_ready()));
         if (m_visible()) begin
            check("D_out", 32'(D_out), 32'(q_m[0].d));
            check("out_sat", 32'(out_sat), 32'(q_m[0].sat));
            check("D_out_small", 32'(D_out_s), 32'(q_m[0].d));
            check("out_sat_small", 32'(out_sat_s), 32'(q_m[0].sat));
         end
         check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
         check("ovf_count", 32'(ovf_count), 32'(m_count));
         check("ovf_sticky_small", 32'(ovf_sticky_s), 32'(m_sticky));
         check("ovf_count_small", 32'(ovf_count_s), 32'(m_count_s));
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] stim[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single sample with out_ready held high; pins latency and result literally.
   task automatic directed(input string name, input logic [31:0] x,
                           input logic [15:0] exp_d, input logic exp_sat);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      D_in      = x;
      tick();
      in_valid  = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      check({name, "_latency"}, 32'(lat), 32'd2);
      check({name, "_d"}, 32'(D_out), 32'(exp_d));
      check({name, "_sat"}, 32'(out_sat), 32'(exp_sat));
      tick();
   endtask

   // mode 0: out_ready high; 1: out_ready low for cycles 2..7; 2: random out_ready.
   task automatic run_stream(input string name, input int mode);
      int  i, cyc;
      bit  acc, saw_block;
      i = 0; cyc = 0; saw_block = 1'b0;
      while ((i < stim.size() || q_m.size() > 0) && cyc < 40000) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !(cyc >= 2 && cyc <= 7);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         in_valid = (i < stim.size());
         D_in     = in_valid ? stim[i] : 32'h0;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (in_valid && !in_ready) saw_block = 1'b1;
         @(posedge clk);
         #1;
         if (acc) i++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check({name, "_drained"}, 32'(q_m.size()), 32'd0);
      check({name, "_all_sent"}, 32'(i), 32'(stim.size()));
      if (mode == 1) check({name, "_in_ready_dropped"}, 32'(saw_block), 32'd1);
   endtask

   initial begin
      int count_before;
      logic [31:0] r;

      @(posedge clk);
      #1;
      started = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_D_out", 32'(D_out), 32'h0);
      check("reset_out_sat", 32'(out_sat), 32'h0);
      check("reset_in_ready", 32'(in_ready), 32'h1);
      check("reset_ovf_count", 32'(ovf_count), 32'h0);
      tick();

      // Rounding and round trip
      directed("round_up",   32'h0012_3480, 16'h1235, 1'b0);
      directed("round_down", 32'h0012_347F, 16'h1234, 1'b0);
      directed("neg_half",   32'hFFFF_FF80, 16'h0000, 1'b0);
      directed("roundtrip",  32'h0012_3400, 16'h1234, 1'b0);

      // Saturation
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      directed("sat_pos", 32'h0080_0000, 16'h7FFF, 1'b1);
      directed("sat_neg", 32'hFF7F_FF00, 16'h8000, 1'b1);
      @(negedge clk);
      check("sat_count_after_two", 32'(ovf_count), 32'd2);
      check("sat_sticky_after_two", 32'(ovf_sticky), 32'd1);
      tick();
      directed("near_max", 32'h007F_FF7F, 16'h7FFF, 1'b0);

      // Identity sweep of the left-shift round trip
      count_before = int'(ovf_count);
      stim.delete();
      for (int x = 0; x < 32768; x++) stim.push_back({8'h00, 16'(x), 8'h00});
      run_stream("sweep", 0);
      @(negedge clk);
      check("sweep_no_sat", 32'(ovf_count), 32'(count_before));
      tick();

      // Backpressure: six samples, out_ready low for cycles 2..7
      stim.delete();
      for (int k = 0; k < 6; k++) stim.push_back(32'h0001_0000 * 32'(k + 1) + 32'h80);
      run_stream("backpressure", 1);

      // Random out_ready with mixed in-range and saturating samples
      stim.delete();
      for (int k = 0; k < 40; k++) begin
         r = $urandom();
         stim.push_back((k % 2 == 1) ? r : {{9{r[22]}}, r[22:0]});
      end
      run_stream("random", 2);

      // clr_ovf coinciding with a saturated transfer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      D_in      = 32'h0080_0000;
      tick();
      in_valid  = 1'b0;
      tick();
      out_ready = 1'b1;
      clr_ovf   = 1'b1;
      tick();
      clr_ovf   = 1'b0;
      @(negedge clk);
      check("clr_coincide_count", 32'(ovf_count), 32'd1);
      check("clr_coincide_sticky", 32'(ovf_sticky), 32'd1);
      check("clr_coincide_count_small", 32'(ovf_count_s), 32'd1);
      tick();

      // Counter ceiling on the narrow instance
      stim.delete();
      for (int k = 0; k < 8; k++) stim.push_back(32'h4000_0000);
      run_stream("ceiling", 0);
      @(negedge clk);
      check("ceiling_small", 32'(ovf_count_s), 32'd7);
      check("ceiling_main", 32'(ovf_count), 32'd9);
      tick();

      // Reset with two samples in flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      D_in      = 32'h0001_0000;
      tick();
      D_in      = 32'h0002_0000;
      tick();
      in_valid  = 1'b0;
      rst       = 1'b1;
      tick();
      rst       = 1'b0;
      @(negedge clk);
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_ovf_count", 32'(ovf_count), 32'd0);
      check("midreset_in_ready", 32'(in_ready), 32'd1);
      tick();
      out_ready = 1'b1;
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
